// File: rtl/interleaver_pkg.sv
// Shared configuration for the convolutional interleaver.
// The commutator controller and the reg_buffer wrappers both import it.
//   N_BRANCH  : number of branches. Branch 0 is the direct, zero-delay path.
//   M_DEPTH   : delay added per branch. Branch j delays by j*M_DEPTH bytes.
//   DW        : symbol width.
//   SYNC_BYTE : TS sync byte, used when SYNC_ALIGN_EN is defined.
//   FILL      : number of accepted bytes that fills every branch buffer.
//   bidx_w()  : width of a branch index.
package interleaver_pkg;
  localparam int N_BRANCH = 12;
  localparam int M_DEPTH  = 17;
  localparam int DW       = 8;
  localparam logic [7:0] SYNC_BYTE = 8'h47;

  function automatic int bidx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int BIDX_W = bidx_w(N_BRANCH);
  localparam int FILL   = M_DEPTH * N_BRANCH * (N_BRANCH - 1);
  localparam int FILL_W = $clog2(FILL + 1);
endpackage

// File: rtl/interleaver_commutator_ctrl_if.sv
// Byte-stream and branch-buffer bus of the interleaver commutator.
//   slave  : the commutator controller.
//   master : the byte source, the branch buffers and the output stage, which surround it.
// Signals:
//   in_valid/data_in         : input byte stream.
//   buf_en/buf_data_in       : shift enables and shared data going to the branch buffers.
//   buf_data_out             : flattened branch outputs. Branch j is at [j*DW +: DW].
//   out_valid/data_out       : interleaved byte stream.
//   branch_idx               : commutator position.
//   primed                   : status flag, set once every branch is filled.
//   slip_count               : status count of sync realignment events.
interface interleaver_commutator_ctrl_if;
  import interleaver_pkg::*;

  logic                     in_valid;
  logic [DW-1:0]            data_in;
  logic [N_BRANCH-1:0]      buf_en;
  logic [DW-1:0]            buf_data_in;
  logic [N_BRANCH*DW-1:0]   buf_data_out;
  logic                     out_valid;
  logic [DW-1:0]            data_out;
  logic [BIDX_W-1:0]        branch_idx;
  logic                     primed;
  logic [7:0]               slip_count;

  modport slave (
    input  in_valid, data_in, buf_data_out,
    output buf_en, buf_data_in, out_valid, data_out, branch_idx, primed, slip_count
  );

  modport master (
    output in_valid, data_in, buf_data_out,
    input  buf_en, buf_data_in, out_valid, data_out, branch_idx, primed, slip_count
  );
endinterface

// File: rtl/interleaver_branch_ptr.sv
// Commutator branch pointer. It is a wrapping counter over 0..N-1.
//   clk, reset : clock and synchronous active-high reset. Reset sets idx to 0.
//   step       : advance by one position, wrapping N-1 -> 0.
//   load_one   : force idx to 1. This is sync realignment: the sync byte was just placed on branch 0.
//                load_one has priority over step.
//   idx        : current position.
module interleaver_branch_ptr
  import interleaver_pkg::*;
#(
  parameter int N = N_BRANCH,
  parameter int W = BIDX_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         load_one,
  output logic [W-1:0] idx
);
  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] ONE  = (N > 1) ? W'(1) : '0;

  always_ff @(posedge clk) begin
    if (reset)
      idx <= '0;
    else if (load_one)
      idx <= ONE;
    else if (step)
      idx <= (idx == LAST) ? '0 : idx + W'(1);
  end
endmodule

// File: rtl/interleaver_commutator.sv
// Top-level commutator controller for the convolutional interleaver.
// Build option: define SYNC_ALIGN_EN to realign the commutator on the TS sync byte (0x47).
// Ports:
//   clk   : clock.
//   reset : synchronous, active-high.
//   bus   : slave modport of interleaver_commutator_ctrl_if. It carries:
//           - the byte stream in and out,
//           - the branch-buffer shift enables and data,
//           - the status outputs branch_idx, primed and slip_count.
// Operation:
//   Each accepted byte goes to the branch selected by the pointer.
//   On the same edge, the oldest byte of that branch is registered onto data_out.
//   Branch 0 has no buffer, so its byte passes straight through.
module interleaver_commutator_ctrl
  import interleaver_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  interleaver_commutator_ctrl_if.slave bus
);
  localparam logic [FILL_W-1:0] FILL_V = FILL_W'(FILL);

  logic                          sync_hit;
  logic [BIDX_W-1:0]             k_sel;
  logic [BIDX_W-1:0]             ptr;
  logic [N_BRANCH-1:0][DW-1:0]   br_q;
  logic [DW-1:0]                 mux_byte;
  logic [FILL_W-1:0]             fill_cnt;

`ifdef SYNC_ALIGN_EN
  assign sync_hit = bus.in_valid && (bus.data_in == SYNC_BYTE);
`else
  assign sync_hit = 1'b0;
`endif

  // A sync byte always goes to branch 0, whatever the pointer says.
  assign k_sel = sync_hit ? '0 : ptr;

  interleaver_branch_ptr #(.N(N_BRANCH), .W(BIDX_W)) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .step     (bus.in_valid),
    .load_one (sync_hit),
    .idx      (ptr)
  );

  assign bus.branch_idx  = ptr;
  assign bus.buf_data_in = bus.data_in;

  // One-hot shift enable. Branch 0 has no buffer, so bit 0 stays low.
  for (genvar j = 0; j < N_BRANCH; j++) begin : g_en
    if (j == 0) begin : g_zero
      assign bus.buf_en[j] = 1'b0;
    end else begin : g_br
      assign bus.buf_en[j] = bus.in_valid && (k_sel == BIDX_W'(j));
    end
  end

  assign br_q = bus.buf_data_out;

  // The buffer output is its pre-shift (oldest) byte.
  // That byte leaves on the same edge that shifts the new byte in.
  assign mux_byte = (k_sel == '0) ? bus.data_in : br_q[k_sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.data_out  <= '0;
      fill_cnt      <= '0;
      bus.primed    <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.data_out <= mux_byte;
        if (fill_cnt != FILL_V)
          fill_cnt <= fill_cnt + FILL_W'(1);
        // primed is set on the same edge that brings the count to FILL.
        if (fill_cnt == FILL_V - FILL_W'(1))
          bus.primed <= 1'b1;
      end
    end
  end

`ifdef SYNC_ALIGN_EN
  logic [7:0] slip_q;
  always_ff @(posedge clk) begin
    if (reset)
      slip_q <= '0;
    else if (sync_hit && (ptr != '0) && (slip_q != 8'hFF))
      slip_q <= slip_q + 8'd1;
  end
  assign bus.slip_count = slip_q;
`else
  assign bus.slip_count = '0;
`endif
endmodule

// File: tb/tb_interleaver_commutator_ctrl.sv
module tb_interleaver_commutator_ctrl;
  import interleaver_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  interleaver_commutator_ctrl_if bus();
  interleaver_commutator_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural branch buffers: branch j is a circular FIFO of depth j*M_DEPTH.
  logic [DW-1:0] mem [N_BRANCH][M_DEPTH*(N_BRANCH-1)];
  int            wp  [N_BRANCH];

  always @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < N_BRANCH; j++) begin
        wp[j] <= 0;
        for (int a = 0; a < M_DEPTH*(N_BRANCH-1); a++) mem[j][a] <= '0;
      end
    end else begin
      for (int j = 1; j < N_BRANCH; j++)
        if (bus.buf_en[j]) begin
          mem[j][wp[j]] <= bus.buf_data_in;
          wp[j] <= (wp[j] == j*M_DEPTH-1) ? 0 : wp[j] + 1;
        end
    end
  end

  always_comb begin
    bus.buf_data_out = '0;
    for (int j = 1; j < N_BRANCH; j++)
      bus.buf_data_out[j*DW +: DW] = mem[j][wp[j]];
  end

  // Expected state
  int            e_idx = 0, e_fill = 0, e_slip = 0;
  logic          e_ov = 1'b0, e_primed = 1'b0;
  logic [DW-1:0] e_dout = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle.
  // Before the edge: check the combinational outputs.
  // After the edge (#1): check the registered state.
  task automatic drive(input logic v, input logic [7:0] d, input logic rst);
    int k;
    logic sy;
    logic [31:0] ebe;
    logic [DW-1:0] nd;
    reset = rst; bus.in_valid = v; bus.data_in = d;
`ifdef SYNC_ALIGN_EN
    sy = v && (d == SYNC_BYTE);
`else
    sy = 1'b0;
`endif
    k = sy ? 0 : e_idx;
    @(negedge clk);
    nd = (k == 0) ? d : mem[k][wp[k]];
    if (!rst) begin
      ebe = (v && k != 0) ? (32'd1 << k) : 32'd0;
      chk("branch_idx_pre", 32'(bus.branch_idx), e_idx);
      chk("buf_en", 32'(bus.buf_en), ebe);
      chk("buf_data_in", 32'(bus.buf_data_in), 32'(d));
    end
    @(posedge clk); #1;
    if (rst) begin
      e_idx = 0; e_fill = 0; e_slip = 0; e_ov = 0; e_primed = 0; e_dout = '0;
    end else if (v) begin
      e_ov = 1'b1; e_dout = nd;
      if (sy) begin
        if (e_idx != 0 && e_slip < 255) e_slip++;
        e_idx = 1;
      end else e_idx = (e_idx + 1) % N_BRANCH;
      if (e_fill < FILL) e_fill++;
      if (e_fill == FILL) e_primed = 1'b1;
    end else e_ov = 1'b0;
    chk("out_valid", 32'(bus.out_valid), 32'(e_ov));
    chk("data_out", 32'(bus.data_out), 32'(e_dout));
    chk("branch_idx", 32'(bus.branch_idx), e_idx);
    chk("primed", 32'(bus.primed), 32'(e_primed));
    chk("slip_count", 32'(bus.slip_count), e_slip);
  endtask

  initial begin
    reset = 1'b1; bus.in_valid = 1'b0; bus.data_in = '0;

    // Reset state
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 1);
    chk("rst_idx", 32'(bus.branch_idx), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_data_out", 32'(bus.data_out), 0);
    chk("rst_primed", 32'(bus.primed), 0);
    chk("rst_slip", 32'(bus.slip_count), 0);

    // Test 1: 24 continuous bytes, pointer wraps at byte 12
    for (int i = 0; i < 24; i++) begin
      drive(1, 8'(i), 0);
      if (i == 11) chk("t1_wrap", 32'(bus.branch_idx), 0);
    end

    // Test 2: 0xA5 on branch 0 appears one cycle later
    chk("t2_idx0", 32'(bus.branch_idx), 0);
    drive(1, 8'hA5, 0);
    chk("t2_dout", 32'(bus.data_out), 32'h A5);
    chk("t2_ov", 32'(bus.out_valid), 1);
    drive(0, 8'h00, 0);
    chk("t2_ov_drop", 32'(bus.out_valid), 0);
    chk("t2_hold", 32'(bus.data_out), 32'hA5);

    // Test 3: alternating valid, 48 bytes
    for (int i = 0; i < 96; i++) drive(i % 2 == 0, 8'h10 + 8'(i), 0);

    // Test 4: prime, then the 0x33 round trip through branch 1
    drive(0, 8'h00, 1);
    for (int i = 0; i < FILL; i++) begin
      drive(1, (i == 13) ? 8'h33 : (8'h80 | 8'(i & 8'h3F)), 0);
      if (i == 217) chk("t4_0x33_return", 32'(bus.data_out), 32'h33);
      if (i == FILL-2) chk("t4_not_primed", 32'(bus.primed), 0);
      if (i == FILL-1) chk("t4_primed", 32'(bus.primed), 1);
    end

    // Test 5: sync byte at branch_idx 5, then at 0
    drive(0, 8'h00, 1);
    for (int i = 0; i < 5; i++) drive(1, 8'h01, 0);
    chk("t5_at5", 32'(bus.branch_idx), 5);
    drive(1, 8'h47, 0);
`ifdef SYNC_ALIGN_EN
    chk("t5_sync_dout", 32'(bus.data_out), 32'h47);
    chk("t5_sync_idx", 32'(bus.branch_idx), 1);
    chk("t5_slip1", 32'(bus.slip_count), 1);
    for (int i = 0; i < 11; i++) drive(1, 8'h02, 0);
    chk("t5_at0", 32'(bus.branch_idx), 0);
    drive(1, 8'h47, 0);
    chk("t5_slip_hold", 32'(bus.slip_count), 1);
    chk("t5_idx1", 32'(bus.branch_idx), 1);
`else
    chk("t5_freerun_idx", 32'(bus.branch_idx), 6);
    chk("t5_slip0", 32'(bus.slip_count), 0);
`endif

    // Test 6: reset during a primed stream, at byte 100
    drive(0, 8'h00, 1);
    for (int i = 0; i < FILL + 100; i++) drive(1, 8'h90, 0);
    chk("t6_primed_before", 32'(bus.primed), 1);
    drive(1, 8'h91, 1);
    chk("t6_idx", 32'(bus.branch_idx), 0);
    chk("t6_ov", 32'(bus.out_valid), 0);
    chk("t6_primed", 32'(bus.primed), 0);
    chk("t6_fill", 32'(dut.fill_cnt), 0);
    drive(1, 8'h92, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
